// File: rtl/iir_pkg.sv
// iir_pkg: coefficient layout, FSM encoding and fixed-point helpers shared by
// the biquad datapath and the sequencing engine.
package iir_pkg;

    localparam int B0    = 0;
    localparam int B1    = 1;
    localparam int B2    = 2;
    localparam int A1    = 3;
    localparam int A2    = 4;
    localparam int NCOEF = 5;

    // Widest accumulator the helpers handle; DW+CW+GUARD must not exceed it.
    localparam int ACC_MAX = 96;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2
    } state_e;

    // Coefficients are Q2.(CW-2): products carry CW-2 extra fraction bits.
    function automatic int q_shift(input int cw);
        return cw - 2;
    endfunction

    function automatic logic signed [ACC_MAX-1:0] q_half(input int cw);
        return ACC_MAX'(1) <<< (cw - 3);
    endfunction

    // Round half up back to Q1.(dw-1) and clip to the signed dw-bit range.
    function automatic logic signed [ACC_MAX-1:0] round_sat(
        input  logic signed [ACC_MAX-1:0] sum,
        input  int                        dw,
        input  int                        cw,
        output logic                      sat
    );
        logic signed [ACC_MAX-1:0] r;
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        r   = (sum + q_half(cw)) >>> q_shift(cw);
        hi  = (ACC_MAX'(1) <<< (dw - 1)) - ACC_MAX'(1);
        lo  = -(ACC_MAX'(1) <<< (dw - 1));
        sat = (r > hi) || (r < lo);
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

endpackage

// File: rtl/iir_sos_engine_if.sv
// iir_sos_engine_if: sample stream, control and coefficient-load bus of the
// time-multiplexed biquad engine.
interface iir_sos_engine_if #(
    parameter int DW       = 24,
    parameter int CW       = 24,
    parameter int STAGES   = 4,
    parameter int CHANNELS = 2
);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW  = $clog2(STAGES * 5);

    logic signed [DW-1:0]  in_data;
    logic [CHW-1:0]        in_ch;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  out_data;
    logic [CHW-1:0]        out_ch;
    logic                  out_valid;
    logic                  bypass;
    logic                  clear_state;
    logic                  coef_we;
    logic [AW-1:0]         coef_addr;
    logic signed [CW-1:0]  coef_wdata;
    logic                  coef_err;
    logic                  sat_flag;

    modport master (
        output in_data, in_ch, in_valid, bypass, clear_state,
               coef_we, coef_addr, coef_wdata,
        input  in_ready, out_data, out_ch, out_valid, coef_err, sat_flag
    );

    modport slave (
        input  in_data, in_ch, in_valid, bypass, clear_state,
               coef_we, coef_addr, coef_wdata,
        output in_ready, out_data, out_ch, out_valid, coef_err, sat_flag
    );

endinterface

// File: rtl/iir_biquad_mac.sv
// iir_biquad_mac: combinational biquad datapath. PH_A forms the feedback node
// w0, PH_B the feed-forward output y; both are rounded and saturated.
module iir_biquad_mac
    import iir_pkg::*;
#(
    parameter int DW    = 24,
    parameter int CW    = 24,
    parameter int GUARD = 4
) (
    input  logic                 phase_b,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] w0,
    input  logic signed [DW-1:0] w1,
    input  logic signed [DW-1:0] w2,
    input  logic signed [CW-1:0] b0,
    input  logic signed [CW-1:0] b1,
    input  logic signed [CW-1:0] b2,
    input  logic signed [CW-1:0] a1,
    input  logic signed [CW-1:0] a2,
    output logic signed [DW-1:0] result,
    output logic                 sat
);

    localparam int PW = DW + CW;
    localparam int SW = PW + GUARD;

    logic signed [CW-1:0] c1;
    logic signed [CW-1:0] c2;
    logic signed [PW-1:0] p0;
    logic signed [PW-1:0] p1;
    logic signed [PW-1:0] p2;
    logic signed [SW-1:0] t0;
    logic signed [SW-1:0] t1;
    logic signed [SW-1:0] t2;
    logic signed [SW-1:0] sum;

    // NOTE: every signal written here is assigned on every path, so no latches.
    always_comb begin
        c1  = phase_b ? b1 : a1;
        c2  = phase_b ? b2 : a2;
        p0  = PW'(b0) * PW'(w0);
        p1  = PW'(c1) * PW'(w1);
        p2  = PW'(c2) * PW'(w2);
        // Feedback terms are subtracted as products so a = -2.0 never needs negating.
        t0  = phase_b ? SW'(p0) : (SW'(x) <<< q_shift(CW));
        t1  = phase_b ? SW'(p1) : -SW'(p1);
        t2  = phase_b ? SW'(p2) : -SW'(p2);
        sum = t0 + t1 + t2;
        sat = 1'b0;
        result = DW'(round_sat(ACC_MAX'(sum), DW, CW, sat));
    end

endmodule

// File: rtl/iir_sos_engine.sv
// iir_sos_engine: multi-channel biquad cascade sharing one MAC; an FSM walks
// each accepted sample through STAGES x (PH_A, PH_B).
module iir_sos_engine
    import iir_pkg::*;
#(
    parameter int DW       = 24,
    parameter int CW       = 24,
    parameter int STAGES   = 4,
    parameter int CHANNELS = 2,
    parameter int GUARD    = 4
) (
    input logic           clk,
    input logic           rst,
    iir_sos_engine_if.slave bus
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SGW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int NC  = STAGES * NCOEF;
    localparam int NS  = CHANNELS * STAGES;
    localparam logic signed [CW-1:0] B0_ONE = CW'(1) <<< q_shift(CW);

    state_e               state_q, state_d;
    logic [SGW-1:0]       stage_q;
    logic [CHW-1:0]       ch_q;
    logic                 bypass_q;
    logic signed [DW-1:0] x_q;
    logic signed [DW-1:0] w0_q;
    logic signed [CW-1:0] coef [NC];
    logic signed [DW-1:0] w1_mem [NS];
    logic signed [DW-1:0] w2_mem [NS];

    logic signed [DW-1:0] out_data_q;
    logic [CHW-1:0]       out_ch_q;
    logic                 out_valid_q;
    logic                 coef_err_q;
    logic                 sat_flag_q;

    logic                 in_ready;
    logic                 accept;
    logic                 clear_go;
    logic                 coef_ok;
    logic                 last_stage;
    int                   sidx;
    int                   cbase;
    logic signed [DW-1:0] mac_res;
    logic                 mac_sat;

    assign in_ready   = (state_q == IDLE) && !bus.clear_state;
    assign accept     = in_ready && bus.in_valid;
    assign clear_go   = (state_q == IDLE) && bus.clear_state;
    assign coef_ok    = bus.coef_we && (state_q == IDLE) && (int'(bus.coef_addr) < NC);
    assign last_stage = (int'(stage_q) == STAGES - 1);
    assign sidx       = int'(ch_q) * STAGES + int'(stage_q);
    assign cbase      = int'(stage_q) * NCOEF;

    iir_biquad_mac #(.DW(DW), .CW(CW), .GUARD(GUARD)) u_mac (
        .phase_b (state_q == PH_B),
        .x       (x_q),
        .w0      (w0_q),
        .w1      (w1_mem[sidx]),
        .w2      (w2_mem[sidx]),
        .b0      (coef[cbase + B0]),
        .b1      (coef[cbase + B1]),
        .b2      (coef[cbase + B2]),
        .a1      (coef[cbase + A1]),
        .a2      (coef[cbase + A2]),
        .result  (mac_res),
        .sat     (mac_sat)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = PH_A;
            PH_A:    state_d = PH_B;
            PH_B:    state_d = last_stage ? IDLE : PH_A;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: coefficient and state arrays are reset explicitly, because reset
    // must restore identity coefficients and zero filter history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) coef[i] <= (i % NCOEF == B0) ? B0_ONE : '0;
            coef_err_q <= 1'b0;
        end else begin
            coef_err_q <= bus.coef_we && !coef_ok;
            if (coef_ok) coef[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            ch_q        <= '0;
            bypass_q    <= 1'b0;
            x_q         <= '0;
            w0_q        <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                w1_mem[i] <= '0;
                w2_mem[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (clear_go) begin
                        sat_flag_q <= 1'b0;
                        for (int i = 0; i < NS; i++) begin
                            w1_mem[i] <= '0;
                            w2_mem[i] <= '0;
                        end
                    end else if (accept) begin
                        x_q      <= bus.in_data;
                        ch_q     <= bus.in_ch;
                        bypass_q <= bus.bypass;
                        stage_q  <= '0;
                    end
                end
                PH_A: begin
                    w0_q <= mac_res;
                    if (mac_sat && !bypass_q) sat_flag_q <= 1'b1;
                end
                PH_B: begin
                    // A bypassed sample rides through x_q; history stays untouched.
                    if (!bypass_q) begin
                        x_q          <= mac_res;
                        w1_mem[sidx] <= w0_q;
                        w2_mem[sidx] <= w1_mem[sidx];
                        if (mac_sat) sat_flag_q <= 1'b1;
                    end
                    if (last_stage) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= bypass_q ? x_q : mac_res;
                        out_ch_q    <= ch_q;
                    end else begin
                        stage_q <= stage_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
    assign bus.coef_err  = coef_err_q;
    assign bus.sat_flag  = sat_flag_q;

endmodule

// File: doc/iir_sos_engine.md
# iir_sos_engine

Parametrised, time-multiplexed cascade of direct-form-II second-order sections (biquads) for multi-channel 24-bit sample streams. It is the successor to the fixed four-stage, single-channel SOS chain:
- stage count, data/coefficient widths and channel count are parameters;
- coefficients are run-time loadable;
- filter state is held per channel;
- one shared biquad datapath is sequenced by an FSM.

It sits between the sample source and the downstream decimation/output logic.

## Interface
- DW, 24: sample and state width, signed Q1.(DW-1)
- CW, 24: coefficient width, signed Q2.(CW-2), range [-2, 2)
- STAGES, 4: number of cascaded SOS stages, 1..8
- CHANNELS, 2: independent channels, 1..16
- GUARD, 4: accumulator guard bits
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  DW  input sample
- in_ch  in  clog2(CHANNELS) (min 1)  channel of input sample
- in_valid  in  1  input sample valid
- in_ready  out  1  engine can accept a sample
- out_data  out  DW  filtered sample
- out_ch  out  clog2(CHANNELS) (min 1)  channel of out_data
- out_valid  out  1  one-cycle pulse, out_data/out_ch valid
- bypass  in  1  sampled at accept; sample passes unfiltered
- clear_state  in  1  zero all state, all channels
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(STAGES*5)  address = stage*5 + idx; idx order: b0, b1, b2, a1, a2
- coef_wdata  in  CW  coefficient value
- coef_err  out  1  one-cycle pulse: write dropped
- sat_flag  out  1  sticky: any saturation since last clear_state

## Operation
- Per stage, with x the stage input:
  - w0 = x − a1·w1 − a2·w2
  - y = b0·w0 + b1·w1 + b2·w2
  - then w2←w1, w1←w0
  - y of stage s is x of stage s+1.
- State w1, w2 is stored per (channel, stage). Channels never share state.
- FSM states and transitions:
  - IDLE: accepts a sample on in_valid&in_ready, then goes to PH_A of stage 0.
  - PH_A: computes w0.
  - PH_B: computes y and updates state. Goes to PH_A of the next stage, or to IDLE after the last stage, registering out_data and pulsing out_valid.
- Ready, clear and bypass:
  - in_ready = (state==IDLE) && !clear_state.
  - clear_state in IDLE zeroes all w1/w2 and clears sat_flag in one cycle. It wins over in_valid in the same cycle.
  - clear_state outside IDLE is ignored.
  - bypass at accept: out_data = in_data with normal latency. State and sat_flag are untouched.
- Arithmetic:
  - Products are DW+CW bits; sums use DW+CW+GUARD bits.
  - Result = (sum + 2^(CW-3)) >>> (CW-2), i.e. round half up.
  - The result saturates to [-2^(DW-1), 2^(DW-1)-1]. Any clip sets sat_flag.
  - w0 and y are both saturated before storage or forwarding.
- Coefficient writes:
  - Honoured only in IDLE and take effect on the next accepted sample.
  - coef_we outside IDLE is dropped and coef_err pulses in the following cycle.
  - Address ≥ STAGES*5 is dropped and coef_err pulses.
- Reset state:
  - Coefficients are identity: b0 = 2^(CW-2), all others 0.
  - All state is 0, FSM is in IDLE.
  - in_ready=1, out_valid=0, out_data=0, out_ch=0, coef_err=0, sat_flag=0.
- Reset mid-operation aborts the sample in flight: no out_valid, and state returns to zero.

## Timing
- Sample accepted at edge E0. Stage s PH_A is at edge E0+2s+1 and PH_B at E0+2s+2.
- out_valid is high during the cycle after edge E0+2·STAGES. Latency is 2·STAGES+1 cycles (9 at default).
- in_ready rises together with out_valid. Next accept is possible at edge E0+2·STAGES+1, so minimum spacing is 2·STAGES+1 cycles.
- out_data and out_ch hold their value until the next out_valid.
- coef_err is registered: it occurs one cycle after the offending coef_we.
- sat_flag sets at the edge that registers the clipped value.

## Structure
- Package iir_pkg holds:
  - coefficient index constants B0, B1, B2, A1, A2 and the per-stage count 5;
  - the FSM state enum;
  - Q-format shift and round constants;
  - a round-and-saturate function parametrised by widths.
- Sub-module iir_biquad_mac is the combinational datapath: it selects PH_A or PH_B products and sums, rounds and saturates, and outputs result plus sat.
- The top holds the FSM, coefficient register file and per-channel state arrays.

## Test plan
- Reset, then idle: in_ready=1, all outputs 0. Default coefficients; input 1000 on ch0 → out_data=1000, out_ch=0, exactly 9 cycles after accept.
- Recursion: program stage0 a1 = −0.5 (coef −2^21), others identity. Impulse 4194304 then zeros on ch0 → 4194304, 2097152, 1048576, 524288.
- Channel isolation: same recursion setup, with ch1 samples 0 interleaved with the ch0 impulse train → ch1 outputs all 0 and the ch0 sequence is unchanged.
- Saturation: stage0 b0 = 1.5 (3·2^21), input 8000000 → out_data = 8388607 and sat_flag=1. clear_state in IDLE → sat_flag=0 and next impulse response restarts from zero state.
- Illegal writes:
  - coef_we during busy → coef_err pulses one cycle later and the coefficient is unchanged.
  - coef_addr = 20 at default → coef_err pulses.
- Back-to-back in_valid held high: accepts spaced exactly 9 cycles. Bypass sample 1234 → 1234 out, state unaffected. rst asserted at cycle 4 of a sample → no out_valid, in_ready=1 after release.
